plru_engine: RTL and testbench

Sequential tree-PLRU replacement engine holding per-set pseudo-LRU state for a set-associative last-level cache. The engine generalises the per-set PLRU update/victim functions to a parametrised way count and set count, and adds on-chip state storage, a request/response handshake, a post-reset state sweep and an optional invalid-way-first victim policy. It sits beside the tag array and is driven by the cache controller on every hit, fill and eviction decision.

---
 rtl/plru_engine.sv | 225 ++++++++++++++++++++++
 tb/tb_plru_engine.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/plru_engine.sv
// Tree-PLRU state engine: per-set N_WAY-1 bit trees with TOUCH/VICTIM/PEEK/CLEAR; PLRU_INVALID_FIRST_EN picks lowest invalid way first.
// Latency: accept at edge T, rsp_valid in cycle T+2; INIT sweep of N_SET cycles after reset.
// Backpressure: req_ready only in IDLE (one request per 3 cycles); response path has none.
module plru_engine #(
    parameter int N_WAY = 16,
    parameter int N_SET = 64,
    localparam int WW = $clog2(N_WAY),
    localparam int SW = (N_SET > 1) ? $clog2(N_SET) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [SW-1:0]    req_set,
    input  logic [WW-1:0]    req_way,
    input  logic [N_WAY-1:0] req_valid_mask,
    output logic             rsp_valid,
    output logic [WW-1:0]    rsp_way,
    output logic             rsp_err
);

    localparam int NB = N_WAY - 1;

    localparam logic [1:0] OP_TOUCH  = 2'b00;
    localparam logic [1:0] OP_VICTIM = 2'b01;
    localparam logic [1:0] OP_PEEK   = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_LOOKUP, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     init_cnt_q, init_cnt_d;
    logic [1:0]        op_q, op_d;
    logic [SW-1:0]     set_q, set_d;
    logic [WW-1:0]     way_q, way_d;
    logic              err_q, err_d;
    logic [NB-1:0]     entry_q, entry_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [WW-1:0]     rsp_way_q, rsp_way_d;
    logic              rsp_err_q, rsp_err_d;

    logic [NB-1:0]     mem [N_SET];
    logic              mem_we;
    logic [SW-1:0]     mem_waddr;
    logic [NB-1:0]     mem_wdata;

    logic [WW-1:0]     tree_victim;
    logic [WW-1:0]     victim;
    logic [WW-1:0]     mru_way;
    logic [NB-1:0]     touched;
    logic [WW-1:0]     result;

`ifdef PLRU_INVALID_FIRST_EN
    logic [N_WAY-1:0]  mask_q, mask_d;
`else
    logic              unused_mask;
    assign unused_mask = ^req_valid_mask;
`endif

    // Victim walk: at each node go opposite the stored bit.
    always_comb begin
        logic [WW-1:0] nd;
        logic          b;
        nd          = '0;
        b           = 1'b0;
        tree_victim = '0;
        for (int lvl = 0; lvl < WW; lvl++) begin
            b                       = ~entry_q[nd];
            tree_victim[WW-1-lvl]   = b;
            nd = WW'({nd, 1'b0} + (WW+1)'(1) + (WW+1)'(b));
        end
    end

`ifdef PLRU_INVALID_FIRST_EN
    always_comb begin
        victim = tree_victim;
        for (int i = N_WAY - 1; i >= 0; i--) begin
            if (!mask_q[i]) victim = WW'(i);
        end
    end
`else
    assign victim = tree_victim;
`endif

    // MRU update: every node on the way's path points toward that way.
    always_comb begin
        logic [WW-1:0] nd;
        logic          b;
        nd      = '0;
        b       = 1'b0;
        mru_way = (op_q == OP_TOUCH) ? way_q : victim;
        touched = entry_q;
        for (int lvl = 0; lvl < WW; lvl++) begin
            b           = mru_way[WW-1-lvl];
            touched[nd] = b;
            nd = WW'({nd, 1'b0} + (WW+1)'(1) + (WW+1)'(b));
        end
    end

    always_comb begin
        result = '0;
        if (!err_q) begin
            case (op_q)
                OP_TOUCH:  result = way_q;
                OP_VICTIM: result = victim;
                OP_PEEK:   result = victim;
                default:   result = '0;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_INIT;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:   if (init_cnt_q == SW'(N_SET - 1)) state_d = S_IDLE;
            S_IDLE:   if (req_valid) state_d = S_LOOKUP;
            S_LOOKUP: state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_INIT;
        endcase
    end

    // Output / storage-write logic
    always_comb begin
        req_ready = (state_q == S_IDLE);
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        case (state_q)
            S_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = init_cnt_q;
            end
            S_RESP: begin
                mem_we    = !err_q && (op_q != OP_PEEK);
                mem_waddr = set_q;
                mem_wdata = (op_q == OP_CLEAR) ? '0 : touched;
            end
            default: ;
        endcase
    end

    always_comb begin
        init_cnt_d  = (state_q == S_INIT) ? init_cnt_q + 1'b1 : '0;
        op_d        = op_q;
        set_d       = set_q;
        way_d       = way_q;
        err_d       = err_q;
        entry_d     = entry_q;
        rsp_valid_d = 1'b0;
        rsp_way_d   = rsp_way_q;
        rsp_err_d   = rsp_err_q;
`ifdef PLRU_INVALID_FIRST_EN
        mask_d      = mask_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d  = req_op;
                    set_d = req_set;
                    way_d = req_way;
                    err_d = int'(req_set) >= N_SET;
`ifdef PLRU_INVALID_FIRST_EN
                    mask_d = req_valid_mask;
`endif
                end
            end
            S_LOOKUP: entry_d = err_q ? '0 : mem[set_q];
            S_RESP: begin
                rsp_valid_d = 1'b1;
                rsp_way_d   = result;
                rsp_err_d   = err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt_q  <= '0;
            op_q        <= '0;
            set_q       <= '0;
            way_q       <= '0;
            err_q       <= 1'b0;
            entry_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_way_q   <= '0;
            rsp_err_q   <= 1'b0;
`ifdef PLRU_INVALID_FIRST_EN
            mask_q      <= '0;
`endif
        end else begin
            init_cnt_q  <= init_cnt_d;
            op_q        <= op_d;
            set_q       <= set_d;
            way_q       <= way_d;
            err_q       <= err_d;
            entry_q     <= entry_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_way_q   <= rsp_way_d;
            rsp_err_q   <= rsp_err_d;
`ifdef PLRU_INVALID_FIRST_EN
            mask_q      <= mask_d;
`endif
        end
    end

    // Tree storage is cleared by the INIT sweep, so it carries no reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_way   = rsp_way_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_plru_engine.sv
// Drives a 64-set and a 48-set engine with identical requests and checks both against a way/level reference model.
module tb_plru_engine;

    localparam logic [1:0] OP_TOUCH  = 2'b00;
    localparam logic [1:0] OP_VICTIM = 2'b01;
    localparam logic [1:0] OP_PEEK   = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = '0;
    logic [5:0]  req_set = '0;
    logic [3:0]  req_way = '0;
    logic [15:0] req_valid_mask = 16'hFFFF;

    logic        rdy_a, vld_a, err_a;
    logic [3:0]  way_a;
    logic        rdy_b, vld_b, err_b;
    logic [3:0]  way_b;

    plru_engine #(.N_WAY(16), .N_SET(64)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_a),
        .req_op(req_op), .req_set(req_set), .req_way(req_way),
        .req_valid_mask(req_valid_mask), .rsp_valid(vld_a), .rsp_way(way_a), .rsp_err(err_a)
    );

    plru_engine #(.N_WAY(16), .N_SET(48)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_b),
        .req_op(req_op), .req_set(req_set), .req_way(req_way),
        .req_valid_mask(req_valid_mask), .rsp_valid(vld_b), .rsp_way(way_b), .rsp_err(err_b)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: node for level l on the path of way w is (2^l - 1) + (w >> (4 - l)).
    bit mdl [2][64][15];
    int nset [2] = '{64, 48};

    function automatic void m_clear(int k, int s);
        for (int n = 0; n < 15; n++) mdl[k][s][n] = 1'b0;
    endfunction

    function automatic int m_victim(int k, int s, logic [15:0] m);
        int w;
        w = 0;
`ifdef PLRU_INVALID_FIRST_EN
        for (int i = 0; i < 16; i++) if (!m[i]) return i;
`endif
        for (int l = 0; l < 4; l++) w = 2 * w + (mdl[k][s][(1 << l) - 1 + w] ? 0 : 1);
        return w;
    endfunction

    function automatic void m_touch(int k, int s, int w);
        for (int l = 0; l < 4; l++) mdl[k][s][(1 << l) - 1 + (w >> (4 - l))] = ((w >> (3 - l)) & 1) != 0;
    endfunction

    task automatic run_init();
        @(negedge clk);
        chk("rst_rdy_a", rdy_a, 0);  chk("rst_rdy_b", rdy_b, 0);
        chk("rst_vld_a", vld_a, 0);  chk("rst_vld_b", vld_b, 0);
        chk("rst_way_a", way_a, 0);  chk("rst_way_b", way_b, 0);
        chk("rst_err_a", err_a, 0);  chk("rst_err_b", err_b, 0);
        for (int k = 0; k < 2; k++) for (int s = 0; s < 64; s++) m_clear(k, s);
        rst_n = 1'b1;
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            chk($sformatf("init_rdy_a_%0d", c), rdy_a, (c >= 64) ? 1 : 0);
            chk($sformatf("init_rdy_b_%0d", c), rdy_b, (c >= 48) ? 1 : 0);
        end
    endtask

    task automatic do_req(input logic [1:0] op, input int s, input int w, input logic [15:0] m, input string tag);
        int n;
        int ew [2];
        bit ee [2];
        int v;
        n = 0;
        @(negedge clk);
        while (!(rdy_a && rdy_b) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rdy"}, rdy_a && rdy_b, 1);
        for (int k = 0; k < 2; k++) begin
            ee[k] = s >= nset[k];
            ew[k] = 0;
            if (!ee[k]) begin
                case (op)
                    OP_TOUCH:  begin ew[k] = w; m_touch(k, s, w); end
                    OP_VICTIM: begin v = m_victim(k, s, m); ew[k] = v; m_touch(k, s, v); end
                    OP_PEEK:   ew[k] = m_victim(k, s, m);
                    default:   m_clear(k, s);
                endcase
            end
        end
        req_valid = 1'b1;
        req_op = op;
        req_set = 6'(s);
        req_way = 4'(w);
        req_valid_mask = m;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_v0"}, {vld_a, vld_b}, 0);
        @(negedge clk);
        chk({tag, "_v1"}, {vld_a, vld_b}, 0);
        @(negedge clk);
        chk({tag, "_vld"}, {vld_a, vld_b}, 2'b11);
        chk({tag, "_way_a"}, way_a, ew[0]);
        chk({tag, "_way_b"}, way_b, ew[1]);
        chk({tag, "_err_a"}, err_a, ee[0]);
        chk({tag, "_err_b"}, err_b, ee[1]);
        @(negedge clk);
        chk({tag, "_v3"}, {vld_a, vld_b}, 0);
        chk({tag, "_hold_a"}, {err_a, way_a}, {ee[0], 4'(ew[0])});
        chk({tag, "_hold_b"}, {err_b, way_b}, {ee[1], 4'(ew[1])});
    endtask

    initial begin
        int r;
        int s;
        logic [1:0] op;
        logic [15:0] m;

        #23;
        run_init();

        do_req(OP_PEEK,   20, 0, 16'hFFFF, "peek_fresh");
        do_req(OP_TOUCH,   3, 15, 16'hFFFF, "touch3");
        do_req(OP_PEEK,    3, 0, 16'hFFFF, "peek3");
        do_req(OP_VICTIM,  5, 0, 16'hFFFF, "vic5_1");
        do_req(OP_VICTIM,  5, 0, 16'hFFFF, "vic5_2");
        do_req(OP_VICTIM,  5, 0, 16'hFFFF, "vic5_3");
        do_req(OP_PEEK,    9, 0, 16'hFFF7, "peek9_mask");
        do_req(OP_VICTIM,  9, 0, 16'hFFF7, "vic9_mask");
        do_req(OP_TOUCH,   2, 6, 16'hFFFF, "touch2");
        do_req(OP_PEEK,    2, 0, 16'hFFFF, "peek2_a");
        do_req(OP_CLEAR,   2, 0, 16'hFFFF, "clear2");
        do_req(OP_PEEK,    2, 0, 16'hFFFF, "peek2_b");
        do_req(OP_TOUCH,  50, 1, 16'hFFFF, "touch50");
        do_req(OP_VICTIM, 50, 0, 16'hFFFF, "vic50");
        do_req(OP_PEEK,   50, 0, 16'hFFFF, "peek50");
        do_req(OP_PEEK,    2, 0, 16'hFFFF, "peek2_c");
        do_req(OP_CLEAR,  47, 0, 16'hFFFF, "clear47");
        do_req(OP_TOUCH,  63, 9, 16'hFFFF, "touch63");

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            op = (r < 4) ? OP_TOUCH : (r < 7) ? OP_VICTIM : (r < 9) ? OP_PEEK : OP_CLEAR;
            s = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 5);
            m = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF;
            do_req(op, s, $urandom_range(0, 15), m, $sformatf("rnd%0d", i));
        end

        // Reset while a TOUCH sits in LOOKUP: it must never respond.
        @(negedge clk);
        req_valid = 1'b1;
        req_op = OP_TOUCH;
        req_set = 6'd7;
        req_way = 4'd3;
        req_valid_mask = 16'hFFFF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("abort_vld", {vld_a, vld_b}, 0);
        run_init();
        chk("abort_after_init_vld", {vld_a, vld_b}, 0);
        do_req(OP_PEEK, 7, 0, 16'hFFFF, "peek7_after_abort");
        do_req(OP_PEEK, 5, 0, 16'hFFFF, "peek5_after_abort");
        do_req(OP_VICTIM, 7, 0, 16'hFFFF, "vic7_after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
